// File: rtl/mem_pkg.sv
// Shared memory-subsystem widths and line/transaction types.
package mem_pkg;
  localparam int NPHYS            = 56;
  localparam int CACHE_LINE_SIZE  = 512;
  localparam int ACACHE_LINE_SIZE = $clog2(CACHE_LINE_SIZE/8);
  localparam int TSIZE            = 5;
  localparam int LADDR_W          = NPHYS - ACACHE_LINE_SIZE;

  typedef logic [LADDR_W-1:0]         line_addr_t;
  typedef logic [TSIZE-1:0]           trans_t;
  typedef logic [CACHE_LINE_SIZE-1:0] line_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_rr_arb.sv
// One-hot grant among N requesters: fixed priority (lowest index) or
// round-robin starting after the last accepted winner when RR_EN is set.
module mem_rr_arb import mem_pkg::*; #(
  parameter int N     = 2,
  parameter bit RR_EN = 1'b0,
  localparam int IW   = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_start;
  logic          w_any;

  always_comb begin
    w_start = '0;
    if (RR_EN) w_start = (r_last == IW'(N-1)) ? '0 : r_last + 1'b1;
  end

  always_comb begin
    w_any     = 1'b0;
    o_gnt_idx = '0;
    o_gnt     = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_any && i_req[(int'(w_start) + i) % N]) begin
        w_any     = 1'b1;
        o_gnt_idx = IW'((int'(w_start) + i) % N);
      end
    end
    if (i_en && w_any) o_gnt[o_gnt_idx] = 1'b1;
  end

  // Pointer only moves on an accepted grant; reset value makes client 0 first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_last <= IW'(N-1);
    else if (i_en && w_any)  r_last <= o_gnt_idx;
  end
endmodule

// File: rtl/mem_read_arb.sv
// Multi-client line-read arbiter with NOUT tagged outstanding reads and a
// one-entry response buffer. Define MEM_READ_ARB_RR_EN for round-robin grant.
module mem_read_arb
  import mem_pkg::line_addr_t, mem_pkg::trans_t, mem_pkg::line_t;
#(
  parameter int NPHYS            = mem_pkg::NPHYS,
  parameter int CACHE_LINE_SIZE  = mem_pkg::CACHE_LINE_SIZE,
  parameter int ACACHE_LINE_SIZE = $clog2(CACHE_LINE_SIZE/8),
  parameter int TSIZE            = mem_pkg::TSIZE,
  parameter int NRD              = 2,
  parameter int NOUT             = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NRD*(NPHYS-ACACHE_LINE_SIZE)-1:0] rd_addr,
  input  logic [NRD-1:0]                          rd_req,
  output logic [NRD-1:0]                          rd_ack,
  output logic [NRD-1:0]                          rd_valid,
  input  logic [NRD-1:0]                          rd_ready,
  output logic [CACHE_LINE_SIZE-1:0]              rd_data,
  output logic [NPHYS-ACACHE_LINE_SIZE-1:0]       mem_raddr,
  output logic [TSIZE-1:0]                        mem_raddr_trans,
  output logic                                    mem_raddr_req,
  input  logic                                    mem_raddr_ack,
  input  logic [CACHE_LINE_SIZE-1:0]              mem_rdata,
  input  logic [TSIZE-1:0]                        mem_rdata_trans,
  input  logic                                    mem_rdata_req,
  output logic                                    mem_rdata_ack
);
  localparam int LA = NPHYS - ACACHE_LINE_SIZE;
  localparam int CW = mem_pkg::idx_w(NRD);
  localparam int SW = mem_pkg::idx_w(NOUT);

`ifdef MEM_READ_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic [NOUT-1:0]         r_busy;
  logic [NOUT-1:0][CW-1:0] r_owner;
  line_addr_t              r_raddr;
  trans_t                  r_rtrans;
  logic                    r_rreq;
  logic                    r_bvld;
  line_t                   r_bdata;
  logic [CW-1:0]           r_bown;
  logic [SW-1:0]           r_bslot;

  logic          w_free_any;
  logic [SW-1:0] w_free_idx;
  logic          w_accept_ok;
  logic          w_accept;
  logic [CW-1:0] w_win;
  logic          w_hit;
  logic [CW-1:0] w_hit_own;
  logic          w_consume;
  logic          w_rx;

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int s = NOUT-1; s >= 0; s--) begin
      if (!r_busy[s]) begin
        w_free_any = 1'b1;
        w_free_idx = SW'(s);
      end
    end
  end

  // Address register may be reloaded in the same cycle it hands off.
  assign w_accept_ok = reset & w_free_any & (~r_rreq | mem_raddr_ack);

  mem_rr_arb #(.N(NRD), .RR_EN(RR_EN)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (rd_req),
    .i_en      (w_accept_ok),
    .o_gnt     (rd_ack),
    .o_gnt_idx (w_win)
  );

  assign w_accept = |rd_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rreq   <= 1'b0;
      r_raddr  <= '0;
      r_rtrans <= '0;
    end else if (w_accept) begin
      r_rreq   <= 1'b1;
      r_raddr  <= rd_addr[int'(w_win)*LA +: LA];
      r_rtrans <= TSIZE'(w_free_idx);
    end else if (r_rreq && mem_raddr_ack) begin
      r_rreq   <= 1'b0;
    end
  end

  assign mem_raddr       = r_raddr;
  assign mem_raddr_trans = r_rtrans;
  assign mem_raddr_req   = r_rreq;

  // Returned data is kept only if its id names a live slot.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_own = '0;
    for (int s = 0; s < NOUT; s++) begin
      if (r_busy[s] && mem_rdata_trans == TSIZE'(s)) begin
        w_hit     = 1'b1;
        w_hit_own = r_owner[s];
      end
    end
  end

  assign w_consume     = r_bvld & rd_ready[r_bown];
  assign mem_rdata_ack = reset & (~r_bvld | w_consume);
  assign w_rx          = mem_rdata_req & mem_rdata_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bvld  <= 1'b0;
      r_bdata <= '0;
      r_bown  <= '0;
      r_bslot <= '0;
    end else begin
      if (w_consume) r_bvld <= 1'b0;
      if (w_rx && w_hit) begin
        r_bvld  <= 1'b1;
        r_bdata <= mem_rdata;
        r_bown  <= w_hit_own;
        r_bslot <= SW'(mem_rdata_trans);
      end
    end
  end

  // Freed and allocated slots never coincide: allocation picks a slot
  // that was already free before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= '0;
      r_owner <= '0;
    end else begin
      if (w_consume) r_busy[r_bslot] <= 1'b0;
      if (w_accept) begin
        r_busy[w_free_idx]  <= 1'b1;
        r_owner[w_free_idx] <= w_win;
      end
    end
  end

  always_comb begin
    rd_valid = '0;
    if (r_bvld) rd_valid[r_bown] = 1'b1;
  end

  assign rd_data = r_bdata;
endmodule

// File: tb/tb_mem_read_arb.sv
// Bench for mem_read_arb: directed scenarios plus a randomized run against
// a transaction-level model of slots, address hand-off and response buffer.
module tb_mem_read_arb;
  import mem_pkg::*;
  localparam int NRD  = 2;
  localparam int NOUT = 8;
  localparam int LA   = LADDR_W;

`ifdef MEM_READ_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk, reset;
  logic [NRD*LA-1:0] rd_addr;
  logic [NRD-1:0]    rd_req, rd_ack, rd_valid, rd_ready;
  line_t             rd_data, mem_rdata;
  line_addr_t        mem_raddr;
  trans_t            mem_raddr_trans, mem_rdata_trans;
  logic              mem_raddr_req, mem_raddr_ack, mem_rdata_req, mem_rdata_ack;

  int errors = 0;
  int checks = 0;

  mem_read_arb #(.NRD(NRD), .NOUT(NOUT)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_raddr(mem_raddr), .mem_raddr_trans(mem_raddr_trans),
    .mem_raddr_req(mem_raddr_req), .mem_raddr_ack(mem_raddr_ack),
    .mem_rdata(mem_rdata), .mem_rdata_trans(mem_rdata_trans),
    .mem_rdata_req(mem_rdata_req), .mem_rdata_ack(mem_rdata_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic line_t mkline(input line_addr_t a, input int salt);
    line_t l;
    for (int k = 0; k < CACHE_LINE_SIZE/32; k++)
      l[k*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 * (k + salt + 1));
    return l;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rd_req = '0; rd_ready = '0; rd_addr = '0;
    mem_raddr_ack = 1'b0; mem_rdata_req = 1'b0;
    mem_rdata = '0; mem_rdata_trans = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; rd_req = '1; rd_ready = '1; mem_rdata_req = 1'b1; mem_raddr_ack = 1'b1;
    #1;
    checks++;
    if ({rd_ack, rd_valid, mem_raddr_req, mem_rdata_ack} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got ack=%b valid=%b rreq=%b dack=%b, expected all 0",
               rd_ack, rd_valid, mem_raddr_req, mem_rdata_ack);
    end
    checks++;
    if (rd_data !== '0 || mem_raddr !== '0 || mem_raddr_trans !== '0) begin
      errors++;
      $display("FAIL reset_data: got raddr=%h trans=%0d, expected 0", mem_raddr, mem_raddr_trans);
    end
    do_reset();
    #1;
    checks++;
    if (mem_rdata_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_dack: got %b expected 1", mem_rdata_ack);
    end
  endtask

  task automatic test_single();
    line_t l;
    do_reset();
    l = mkline(LA'(64'h1000), 0);
    rd_addr[0 +: LA] = LA'(64'h1000); rd_req = 2'b01; mem_raddr_ack = 1'b1; rd_ready = 2'b01;
    #1;
    checks++;
    if (rd_ack !== 2'b01) begin errors++; $display("FAIL single_ack: got %b expected 01", rd_ack); end
    cyc(); rd_req = '0; #1;
    checks++;
    if (rd_ack !== 2'b00 || mem_raddr_req !== 1'b1 || mem_raddr !== LA'(64'h1000) || mem_raddr_trans !== 5'd0) begin
      errors++;
      $display("FAIL single_raddr: got ack=%b req=%b addr=%h trans=%0d expected 00/1/1000/0",
               rd_ack, mem_raddr_req, mem_raddr, mem_raddr_trans);
    end
    cyc(); #1;
    checks++;
    if (mem_raddr_req !== 1'b0) begin errors++; $display("FAIL single_handoff: got req=%b expected 0", mem_raddr_req); end
    mem_rdata = l; mem_rdata_trans = '0; mem_rdata_req = 1'b1; #1;
    checks++;
    if (mem_rdata_ack !== 1'b1) begin errors++; $display("FAIL single_dack: got %b expected 1", mem_rdata_ack); end
    cyc(); mem_rdata_req = 1'b0; #1;
    checks++;
    if (rd_valid !== 2'b01 || rd_data !== l) begin
      errors++; $display("FAIL single_return: got valid=%b data_ok=%0d expected 01/1", rd_valid, rd_data == l);
    end
    cyc(); #1;
    checks++;
    if (rd_valid !== 2'b00) begin errors++; $display("FAIL single_consume: got valid=%b expected 00", rd_valid); end
  endtask

  task automatic test_arb();
    logic [NRD-1:0] exp;
    do_reset();
    rd_addr = {LA'(64'hAAA0), LA'(64'h5550)}; rd_req = 2'b11; mem_raddr_ack = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      exp = (RR && (n % 2 == 1)) ? 2'b10 : 2'b01;
      checks++;
      if (rd_ack !== exp) begin errors++; $display("FAIL arb_grant%0d: got %b expected %b", n, rd_ack, exp); end
      cyc();
    end
    rd_req = '0;
  endtask

  task automatic test_full();
    do_reset();
    rd_req = 2'b01; mem_raddr_ack = 1'b1; rd_ready = 2'b01;
    for (int n = 0; n < NOUT; n++) begin
      rd_addr[0 +: LA] = LA'(n * 64); #1;
      checks++;
      if (rd_ack !== 2'b01) begin errors++; $display("FAIL full_fill%0d: got %b expected 01", n, rd_ack); end
      cyc();
    end
    rd_addr[0 +: LA] = LA'(64'h9999);
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (rd_ack !== 2'b00) begin errors++; $display("FAIL full_block%0d: got %b expected 00", n, rd_ack); end
      cyc();
    end
    mem_rdata_trans = 5'd3; mem_rdata = mkline(LA'(3 * 64), 3); mem_rdata_req = 1'b1; #1;
    cyc(); mem_rdata_req = 1'b0; #1;
    checks++;
    if (rd_valid !== 2'b01 || rd_ack !== 2'b00) begin
      errors++; $display("FAIL full_free_edge: got valid=%b ack=%b expected 01/00", rd_valid, rd_ack);
    end
    cyc(); #1;
    checks++;
    if (rd_ack !== 2'b01) begin errors++; $display("FAIL full_reuse_ack: got %b expected 01", rd_ack); end
    cyc(); rd_req = '0; #1;
    checks++;
    if (mem_raddr_trans !== 5'd3 || mem_raddr !== LA'(64'h9999)) begin
      errors++; $display("FAIL full_reuse_id: got trans=%0d addr=%h expected 3/9999", mem_raddr_trans, mem_raddr);
    end
  endtask

  task automatic test_backpressure();
    line_t l0, l1;
    l0 = mkline(LA'(64'h700), 0);
    l1 = mkline(LA'(64'h740), 1);
    do_reset();
    rd_req = 2'b10; mem_raddr_ack = 1'b1;
    rd_addr[LA +: LA] = LA'(64'h700); cyc();
    rd_addr[LA +: LA] = LA'(64'h740); cyc();
    rd_req = '0;
    mem_rdata_trans = 5'd0; mem_rdata = l0; mem_rdata_req = 1'b1; cyc();
    mem_rdata_trans = 5'd1; mem_rdata = l1;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (mem_rdata_ack !== 1'b0 || rd_valid !== 2'b10 || rd_data !== l0) begin
        errors++;
        $display("FAIL bp_hold%0d: got dack=%b valid=%b data_ok=%0d expected 0/10/1",
                 n, mem_rdata_ack, rd_valid, rd_data == l0);
      end
      cyc();
    end
    rd_ready = 2'b10; #1;
    checks++;
    if (mem_rdata_ack !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", mem_rdata_ack); end
    cyc(); mem_rdata_req = 1'b0; #1;
    checks++;
    if (rd_valid !== 2'b10 || rd_data !== l1) begin
      errors++; $display("FAIL bp_second: got valid=%b data_ok=%0d expected 10/1", rd_valid, rd_data == l1);
    end
    cyc(); #1;
    checks++;
    if (rd_valid !== 2'b00) begin errors++; $display("FAIL bp_drained: got %b expected 00", rd_valid); end
  endtask

  task automatic test_drop_reset();
    do_reset();
    rd_ready = '1;
    mem_rdata_trans = 5'd7; mem_rdata = mkline(LA'(64'h77), 7); mem_rdata_req = 1'b1; #1;
    checks++;
    if (mem_rdata_ack !== 1'b1) begin errors++; $display("FAIL drop_ack: got %b expected 1", mem_rdata_ack); end
    cyc(); mem_rdata_req = 1'b0; #1;
    checks++;
    if (rd_valid !== 2'b00 || mem_rdata_ack !== 1'b1) begin
      errors++; $display("FAIL drop_novalid: got valid=%b dack=%b expected 00/1", rd_valid, mem_rdata_ack);
    end
    rd_req = 2'b01; mem_raddr_ack = 1'b1; rd_addr[0 +: LA] = LA'(64'h3000);
    repeat (3) cyc();
    reset = 1'b0; #1;
    checks++;
    if ({rd_ack, rd_valid, mem_raddr_req, mem_rdata_ack} !== '0 || mem_raddr !== '0 ||
        mem_raddr_trans !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL rst_mid: got ack=%b valid=%b rreq=%b dack=%b addr=%h expected all 0",
               rd_ack, rd_valid, mem_raddr_req, mem_rdata_ack, mem_raddr);
    end
    @(negedge clk); rd_req = '0; reset = 1'b1; #1;
    checks++;
    if (mem_rdata_ack !== 1'b1 || rd_valid !== 2'b00) begin
      errors++; $display("FAIL rst_mid_release: got dack=%b valid=%b expected 1/00", mem_rdata_ack, rd_valid);
    end
    mem_rdata_trans = 5'd0; mem_rdata = mkline(LA'(64'h3000), 0); mem_rdata_req = 1'b1;
    cyc(); mem_rdata_req = 1'b0; #1;
    checks++;
    if (rd_valid !== 2'b00) begin errors++; $display("FAIL rst_discard: got valid=%b expected 00", rd_valid); end
  endtask

  task automatic test_random();
    bit         busy[NOUT];
    int         own[NOUT];
    line_addr_t saddr[NOUT];
    bit         act[NRD];
    line_addr_t caddr[NRD];
    int         mq[$];
    bit pend, bvld, rsp, cons, axfer, hit;
    line_addr_t paddr;
    int ptrans, bown, bid, rid, last, nacc, nbusy, fid, win;
    line_t bdat, rdat;
    logic [NRD-1:0] exp_ack, exp_rv;
    logic exp_mack;

    do_reset();
    for (int s = 0; s < NOUT; s++) begin busy[s] = 0; own[s] = 0; saddr[s] = '0; end
    for (int c = 0; c < NRD; c++) begin act[c] = 0; caddr[c] = '0; end
    pend = 0; bvld = 0; rsp = 0; paddr = '0; ptrans = 0; bown = 0; bid = 0;
    rid = 0; last = NRD - 1; nacc = 0; bdat = '0; rdat = '0;

    for (int cy = 0; cy < 3000; cy++) begin
      for (int c = 0; c < NRD; c++) begin
        if (!act[c] && $urandom_range(0, 2) == 0) begin
          act[c] = 1; caddr[c] = LA'({$urandom, $urandom});
        end
        rd_req[c] = act[c];
        rd_addr[c*LA +: LA] = caddr[c];
        rd_ready[c] = ($urandom_range(0, 3) != 0);
      end
      mem_raddr_ack = ($urandom_range(0, 2) != 0);
      if (!rsp) begin
        if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
          automatic int j = $urandom_range(0, mq.size() - 1);
          rid = mq[j]; mq.delete(j); rsp = 1;
          rdat = mkline(saddr[rid], rid);
        end else if ($urandom_range(0, 15) == 0) begin
          rid = $urandom_range(NOUT, 31); rsp = 1;
          rdat = mkline(LA'($urandom), 99);
        end
      end
      mem_rdata_req = rsp; mem_rdata_trans = trans_t'(rid); mem_rdata = rdat;
      #1;

      nbusy = 0; fid = -1;
      for (int s = NOUT - 1; s >= 0; s--) begin
        if (busy[s]) nbusy++;
        else fid = s;
      end
      exp_ack = '0; win = -1;
      if (nbusy < NOUT && (!pend || mem_raddr_ack)) begin
        for (int i = 0; i < NRD; i++) begin
          automatic int c = RR ? (last + 1 + i) % NRD : i;
          if (win < 0 && act[c]) win = c;
        end
        if (win >= 0) exp_ack[win] = 1'b1;
      end
      exp_rv = '0;
      if (bvld) exp_rv[bown] = 1'b1;
      exp_mack = !bvld || rd_ready[bown];

      checks++;
      if (rd_ack !== exp_ack) begin
        errors++; $display("FAIL rnd_ack cyc=%0d: got %b expected %b", cy, rd_ack, exp_ack);
      end
      checks++;
      if (mem_raddr_req !== pend || (pend && (mem_raddr !== paddr || mem_raddr_trans !== trans_t'(ptrans)))) begin
        errors++;
        $display("FAIL rnd_raddr cyc=%0d: got req=%b addr=%h trans=%0d expected %b/%h/%0d",
                 cy, mem_raddr_req, mem_raddr, mem_raddr_trans, pend, paddr, ptrans);
      end
      checks++;
      if (rd_valid !== exp_rv || mem_rdata_ack !== exp_mack || (bvld && rd_data !== bdat)) begin
        errors++;
        $display("FAIL rnd_rsp cyc=%0d: got valid=%b dack=%b data_ok=%0d expected %b/%b/1",
                 cy, rd_valid, mem_rdata_ack, rd_data == bdat, exp_rv, exp_mack);
      end

      cons  = bvld && rd_ready[bown];
      axfer = pend && mem_raddr_ack;
      hit   = rsp && exp_mack && rid < NOUT && busy[rid];
      if (rsp && exp_mack) rsp = 0;
      if (cons) begin busy[bid] = 0; bvld = 0; end
      if (hit) begin bvld = 1; bown = own[rid]; bid = rid; bdat = rdat; end
      if (axfer) begin mq.push_back(ptrans); pend = 0; end
      if (win >= 0) begin
        busy[fid] = 1; own[fid] = win; saddr[fid] = caddr[win];
        pend = 1; paddr = caddr[win]; ptrans = fid;
        act[win] = 0; last = win; nacc++;
      end
      cyc();
    end
    checks++;
    if (nacc < 200) begin errors++; $display("FAIL rnd_activity: got %0d accepts expected at least 200", nacc); end
    rd_req = '0; mem_rdata_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rd_req = '0; rd_ready = '0; rd_addr = '0;
    mem_raddr_ack = 1'b0; mem_rdata_req = 1'b0; mem_rdata = '0; mem_rdata_trans = '0;
    test_reset();
    test_single();
    test_arb();
    test_full();
    test_backpressure();
    test_drop_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
